spi_frame_readback: RTL and testbench
=====================================

// Module: spi_frame_readback
// PURPOSE
//  SPI-slave transmit side of the ESP32 link: streams image-buffer bytes out on MISO so the ESP32 can read back a received frame.
//  Reads the BSRAM image buffer through its read port (1-cycle registered read) and serialises bytes MSB-first, SPI mode 0.
//  Samples esp_sclk/esp_cs_n in the sys_clk domain; sits beside the SPI receive logic, sharing pins and the buffer.
// PARAMETERS
//  ADDR_WIDTH   15       BSRAM address width
//  FRAME_BYTES  32768    bytes sent per transaction before switching to FILL_BYTE
//  FILL_BYTE    8'h00    byte sent when frame_valid is low, or after FRAME_BYTES bytes
//  SYNC_STAGES  2        synchroniser depth for esp_sclk and esp_cs_n (>=2)
// PORTS
//  sys_clk      in   1   system clock (27 MHz); the only clock
//  sys_rst_n    in   1   synchronous, active-low reset
//  esp_sclk     in   1   SPI clock from ESP32, asynchronous
//  esp_cs_n     in   1   SPI chip select, active low, asynchronous
//  esp_miso     out  1   serial data to ESP32
//  esp_miso_oe  out  1   MISO drive enable (1 while CS is active)
//  frame_valid  in   1   frame_ready from the receive side; sampled at CS fall
//  bram_addr    out  15  BSRAM read address
//  bram_data    in   8   BSRAM read data, valid 1 cycle after bram_addr
//  busy         out  1   transaction in progress
//  tx_done      out  1   1-cycle pulse after the 8th bit of byte FRAME_BYTES-1
//  bytes_sent   out  16  complete bytes sent this transaction (saturates)
//  overrun_err  out  1   sticky: an SCLK edge arrived before the shift register was primed
// BEHAVIOUR
//  Reset values: all outputs 0, FSM=IDLE, shift/next buffers=FILL_BYTE, address 0.
//  Sync: SYNC_STAGES-FF chain plus a prev register per input. sc_rise, sc_fall, cs_fall and cs_rise are 1-cycle pulses from the synced values.
//  Master timing: SCLK high/low time >=4 sys_clk (about 3.3 MHz max). CS fall to first SCLK rise >=8 sys_clk.
//  FSM IDLE: esp_miso=0, oe=0. On cs_fall: latch src_ok=frame_valid, addr<=0, bytes_sent<=0, bit_cnt<=0 -> PRIME0.
//  PRIME0: bram_addr=0 -> PRIME1 (next cycle).
//  PRIME1: shift_reg<=src_ok?bram_data:FILL_BYTE; bram_addr=1 -> PRIME2.
//  PRIME2: next_buf<=byte 1 (or FILL_BYTE) -> ACTIVE. MISO is valid 3 cycles after the synced CS fall.
//  ACTIVE: esp_miso=shift_reg[7], oe=1.
//    sc_rise: bit_cnt<=bit_cnt+1 (3-bit, wraps).
//      On the 8th rise (bit_cnt==7): bytes_sent++ (saturating); pulse tx_done if bytes_sent==FRAME_BYTES-1.
//    sc_fall with bit_cnt!=0: shift_reg<={shift_reg[6:0],1'b0}.
//    sc_fall with bit_cnt==0 after the first byte: shift_reg<=next_buf; addr<=addr+1; fetch addr+1 into next_buf over the next 2 cycles.
//  Address wraps: 2**ADDR_WIDTH-1 -> 0.
//  A byte index >= FRAME_BYTES, or src_ok==0, loads FILL_BYTE instead of bram_data.
//  Any SCLK edge in PRIME0..2 sets overrun_err. The edge is otherwise ignored. The flag clears only on reset.
//  cs_rise in any state -> IDLE next cycle. A partial byte is not counted; oe drops the same cycle.
//  cs_rise wins over a simultaneous sc_rise/sc_fall. cs_fall in PRIME*/ACTIVE cannot occur without cs_rise first.
//  Reset mid-transaction: return to IDLE. A transaction already under way is not resumed; the next cs_fall restarts at address 0.
//  busy=1 in PRIME*/ACTIVE.
//  frame_valid changes after cs_fall have no effect until the next transaction.
// TESTING
//  1 Reset then idle: hold sys_rst_n=0 for 4 cycles -> all outputs 0; MISO stays 0 and oe=0 with CS high.
//  2 Basic read: BRAM[0..2]=A5,3C,FF, frame_valid=1, 3-byte mode-0 transfer at 2 MHz -> master reads A5 3C FF; bytes_sent=3.
//  3 Invalid frame: frame_valid=0 at CS fall, 2-byte read -> 00 00, no dependence on BRAM contents; bytes_sent=2.
//  4 Full frame and fill: FRAME_BYTES=4, BRAM[0..3]=01..04, 6-byte read -> 01 02 03 04 00 00. tx_done pulses once, after the 32nd SCLK rise.
//  5 CS abort: CS rises after 5 bits of byte 1 -> IDLE next cycle, bytes_sent=1, oe=0. A new transaction returns BRAM[0] first.
//  6 Overrun: first SCLK rise 1 cycle after the synced CS fall -> overrun_err=1 and stays 1 through further transfers until reset.

Source files
------------

// File: rtl/spi_frame_readback.sv
// SPI-slave readback: streams image-buffer bytes MSB-first on MISO (SPI mode 0), FILL_BYTE past the frame or when no frame is held.
// Latency: MISO valid 3 sys_clk after the synchronised CS fall; each byte is refetched 2 cycles after its load edge.
// Backpressure: none; the ESP32 master paces everything via SCLK, and early SCLK edges only raise overrun_err.
module spi_frame_readback #(
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned FRAME_BYTES = 32768,
    parameter logic [7:0]  FILL_BYTE   = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  esp_sclk,
    input  logic                  esp_cs_n,
    output logic                  esp_miso,
    output logic                  esp_miso_oe,
    input  logic                  frame_valid,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [7:0]            bram_data,
    output logic                  busy,
    output logic                  tx_done,
    output logic [15:0]           bytes_sent,
    output logic                  overrun_err
);

    typedef enum logic [2:0] {S_IDLE, S_PRIME0, S_PRIME1, S_PRIME2, S_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s;
    logic                   sc_rise, sc_fall, cs_fall, cs_rise;

    state_t                 state_q, state_d;
    logic                   src_ok_q, src_ok_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  bram_addr_q, bram_addr_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             next_buf_q, next_buf_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   byte_done_q, byte_done_d;
    logic [31:0]            fetch_idx_q, fetch_idx_d;
    logic                   pend1_q, pend1_d, pend2_q, pend2_d;
    logic [15:0]            bytes_sent_q, bytes_sent_d;
    logic                   tx_done_q, tx_done_d;
    logic                   overrun_q, overrun_d;
    logic                   miso_q, miso_d, oe_q, oe_d, busy_q, busy_d;

    // CS chain resets low so a CS already asserted at reset release never looks like a fresh fall
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], esp_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], esp_cs_n};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign sc_rise = sclk_s & ~sclk_prev_q;
    assign sc_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall = ~cs_s & cs_prev_q;
    assign cs_rise = cs_s & ~cs_prev_q;

    // Next-state: priming fetches, bit/byte counting, byte reload and the prefetch pipeline
    always_comb begin
        state_d      = state_q;
        src_ok_d     = src_ok_q;
        addr_d       = addr_q;
        bram_addr_d  = bram_addr_q;
        shift_d      = shift_q;
        next_buf_d   = next_buf_q;
        bit_cnt_d    = bit_cnt_q;
        byte_done_d  = byte_done_q;
        fetch_idx_d  = fetch_idx_q;
        pend1_d      = 1'b0;
        pend2_d      = 1'b0;
        bytes_sent_d = bytes_sent_q;
        tx_done_d    = 1'b0;
        overrun_d    = overrun_q;
        if (cs_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        src_ok_d     = frame_valid;
                        addr_d       = '0;
                        bram_addr_d  = '0;
                        bytes_sent_d = '0;
                        bit_cnt_d    = '0;
                        byte_done_d  = 1'b0;
                        fetch_idx_d  = '0;
                        state_d      = S_PRIME0;
                    end
                end
                S_PRIME0, S_PRIME1, S_PRIME2: begin
                    if (sc_rise || sc_fall) overrun_d = 1'b1;
                    if (state_q == S_PRIME0) begin
                        bram_addr_d = ADDR_WIDTH'(1);
                        fetch_idx_d = 32'd1;
                        state_d     = S_PRIME1;
                    end else if (state_q == S_PRIME1) begin
                        shift_d = src_ok_q ? bram_data : FILL_BYTE;
                        state_d = S_PRIME2;
                    end else begin
                        next_buf_d = (src_ok_q && fetch_idx_q < FRAME_BYTES) ? bram_data : FILL_BYTE;
                        state_d    = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    // Two-cycle prefetch: address presented, then registered data captured
                    pend2_d = pend1_q;
                    if (pend2_q)
                        next_buf_d = (src_ok_q && fetch_idx_q < FRAME_BYTES) ? bram_data : FILL_BYTE;
                    if (sc_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                            if (bytes_sent_q != 16'hFFFF) bytes_sent_d = bytes_sent_q + 16'd1;
                            if (bytes_sent_q == 16'(FRAME_BYTES - 1)) tx_done_d = 1'b1;
                        end
                    end else if (sc_fall) begin
                        if (bit_cnt_q != 3'd0) begin
                            shift_d = {shift_q[6:0], 1'b0};
                        end else if (byte_done_q) begin
                            shift_d     = next_buf_q;
                            addr_d      = addr_q + ADDR_WIDTH'(1);
                            bram_addr_d = addr_q + ADDR_WIDTH'(2);
                            fetch_idx_d = (fetch_idx_q < FRAME_BYTES) ? fetch_idx_q + 32'd1 : fetch_idx_q;
                            pend1_d     = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        miso_d = (state_d == S_ACTIVE) && shift_d[7];
        oe_d   = (state_d == S_ACTIVE);
        busy_d = (state_d != S_IDLE);
    end

    // FSM and datapath registers; outputs are registered decodes of the next state
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            src_ok_q     <= 1'b0;
            addr_q       <= '0;
            bram_addr_q  <= '0;
            shift_q      <= FILL_BYTE;
            next_buf_q   <= FILL_BYTE;
            bit_cnt_q    <= '0;
            byte_done_q  <= 1'b0;
            fetch_idx_q  <= '0;
            pend1_q      <= 1'b0;
            pend2_q      <= 1'b0;
            bytes_sent_q <= '0;
            tx_done_q    <= 1'b0;
            overrun_q    <= 1'b0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_ok_q     <= src_ok_d;
            addr_q       <= addr_d;
            bram_addr_q  <= bram_addr_d;
            shift_q      <= shift_d;
            next_buf_q   <= next_buf_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_done_q  <= byte_done_d;
            fetch_idx_q  <= fetch_idx_d;
            pend1_q      <= pend1_d;
            pend2_q      <= pend2_d;
            bytes_sent_q <= bytes_sent_d;
            tx_done_q    <= tx_done_d;
            overrun_q    <= overrun_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
        end
    end

    assign esp_miso    = miso_q;
    assign esp_miso_oe = oe_q;
    assign bram_addr   = bram_addr_q;
    assign busy        = busy_q;
    assign tx_done     = tx_done_q;
    assign bytes_sent  = bytes_sent_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_spi_frame_readback.sv
// Directed bench for spi_frame_readback: mode-0 master model plus 1-cycle registered BRAM model.
// Frame length is shortened to 4 bytes so the fill and tx_done paths are reachable.
// SCLK half period is 6 sys_clk; all master transitions land on sys_clk falling edges.
`timescale 1ns/1ps
module tb_spi_frame_readback;

    localparam int CLK_HALF  = 20;
    localparam int SCLK_HALF = 240;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        esp_sclk = 1'b0;
    logic        esp_cs_n = 1'b1;
    logic        esp_miso, esp_miso_oe;
    logic        frame_valid = 1'b0;
    logic [14:0] bram_addr;
    logic [7:0]  bram_data;
    logic        busy, tx_done, overrun_err;
    logic [15:0] bytes_sent;

    logic [7:0]  mem [0:63];
    logic [7:0]  rx_buf [0:7];
    int          rx_n;
    int          n_rise;
    int          done_cnt;
    int          done_rise;
    int          n_vec = 0;
    int          n_err = 0;

    spi_frame_readback #(
        .ADDR_WIDTH (15),
        .FRAME_BYTES(4),
        .FILL_BYTE  (8'h00),
        .SYNC_STAGES(2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .esp_sclk   (esp_sclk),
        .esp_cs_n   (esp_cs_n),
        .esp_miso   (esp_miso),
        .esp_miso_oe(esp_miso_oe),
        .frame_valid(frame_valid),
        .bram_addr  (bram_addr),
        .bram_data  (bram_data),
        .busy       (busy),
        .tx_done    (tx_done),
        .bytes_sent (bytes_sent),
        .overrun_err(overrun_err)
    );

    always #CLK_HALF sys_clk = ~sys_clk;

    // Registered-read image buffer
    always @(posedge sys_clk) bram_data <= mem[bram_addr[5:0]];

    // Record every tx_done pulse and how many SCLK rises the master had issued by then
    always @(negedge sys_clk) begin
        if (tx_done) begin
            done_cnt  = done_cnt + 1;
            done_rise = n_rise;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        wait_clk(4);
        sys_rst_n = 1'b1;
        wait_clk(4);
    endtask

    // Mode-0 master read; stop_bits > 0 raises CS after that many bits in total
    task automatic spi_read(input int nbytes, input int stop_bits);
        logic [7:0] rx;
        int limit;
        limit = (stop_bits > 0) ? stop_bits : nbytes * 8;
        rx    = 8'h00;
        rx_n  = 0;
        @(negedge sys_clk);
        esp_cs_n = 1'b0;
        wait_clk(12);
        for (int i = 0; i < limit; i++) begin
            rx = {rx[6:0], esp_miso};
            esp_sclk = 1'b1;
            n_rise = n_rise + 1;
            #SCLK_HALF;
            esp_sclk = 1'b0;
            #SCLK_HALF;
            if ((i % 8) == 7) begin
                rx_buf[rx_n] = rx;
                rx_n = rx_n + 1;
            end
        end
        esp_cs_n = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        logic [7:0] exp4 [0:5];
        exp4[0] = 8'h01; exp4[1] = 8'h02; exp4[2] = 8'h03;
        exp4[3] = 8'h04; exp4[4] = 8'h00; exp4[5] = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 8'h5A;
        n_rise   = 0;
        done_cnt = 0;
        done_rise = 0;

        // 1: reset then idle
        do_reset();
        check("rst_miso", {31'd0, esp_miso}, 32'd0);
        check("rst_oe", {31'd0, esp_miso_oe}, 32'd0);
        check("rst_addr", {17'd0, bram_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_txdone", {31'd0, tx_done}, 32'd0);
        check("rst_bytes", {16'd0, bytes_sent}, 32'd0);
        check("rst_overrun", {31'd0, overrun_err}, 32'd0);
        wait_clk(10);
        check("idle_miso", {31'd0, esp_miso}, 32'd0);
        check("idle_oe", {31'd0, esp_miso_oe}, 32'd0);

        // 2: basic 3-byte read
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF;
        frame_valid = 1'b1;
        spi_read(3, 0);
        check("basic_n", rx_n, 32'd3);
        check("basic_b0", {24'd0, rx_buf[0]}, 32'hA5);
        check("basic_b1", {24'd0, rx_buf[1]}, 32'h3C);
        check("basic_b2", {24'd0, rx_buf[2]}, 32'hFF);
        check("basic_bytes", {16'd0, bytes_sent}, 32'd3);
        check("basic_busy", {31'd0, busy}, 32'd0);
        check("basic_nodone", done_cnt, 32'd0);

        // 3: no valid frame -> fill bytes regardless of buffer contents
        frame_valid = 1'b0;
        spi_read(2, 0);
        check("inval_b0", {24'd0, rx_buf[0]}, 32'h00);
        check("inval_b1", {24'd0, rx_buf[1]}, 32'h00);
        check("inval_bytes", {16'd0, bytes_sent}, 32'd2);

        // 4: whole frame then fill; tx_done on the 32nd rise
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        mem[4] = 8'hEE; mem[5] = 8'hDD;
        frame_valid = 1'b1;
        n_rise   = 0;
        done_cnt = 0;
        spi_read(6, 0);
        for (int i = 0; i < 6; i++)
            check($sformatf("fill_b%0d", i), {24'd0, rx_buf[i]}, {24'd0, exp4[i]});
        check("fill_bytes", {16'd0, bytes_sent}, 32'd6);
        check("fill_done_cnt", done_cnt, 32'd1);
        check("fill_done_rise", done_rise, 32'd32);

        // 5: CS abort after 5 bits of byte 1, then a fresh read restarts at address 0
        mem[0] = 8'hA5; mem[1] = 8'h3C;
        spi_read(2, 13);
        check("abort_bytes", {16'd0, bytes_sent}, 32'd1);
        check("abort_oe", {31'd0, esp_miso_oe}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        spi_read(1, 0);
        check("abort_restart", {24'd0, rx_buf[0]}, 32'hA5);

        // 6: SCLK edge during priming -> sticky overrun until reset
        check("ovr_pre", {31'd0, overrun_err}, 32'd0);
        @(negedge sys_clk);
        esp_cs_n = 1'b0;
        wait_clk(1);
        esp_sclk = 1'b1;
        wait_clk(8);
        esp_sclk = 1'b0;
        wait_clk(8);
        esp_cs_n = 1'b1;
        wait_clk(6);
        check("ovr_set", {31'd0, overrun_err}, 32'd1);
        spi_read(1, 0);
        check("ovr_sticky", {31'd0, overrun_err}, 32'd1);
        check("ovr_data", {24'd0, rx_buf[0]}, 32'hA5);
        do_reset();
        check("ovr_cleared", {31'd0, overrun_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
